// File: rtl/mouse_pos_tracker.sv
// -----------------------------------------------------------------------------
// mouse_pos_tracker
//   Assembles PS/2 mouse packets from a byte receiver and integrates the
//   movement deltas into a clamped on-screen cursor position.
//
//   Optional feature macro: MOUSE_WHEEL_EN
//     defined   -> 4-byte packets (header, X, Y, Z); mouse_z_delta loaded from
//                  Z byte bits [3:0]
//     undefined -> 3-byte packets; BYTE3 state absent; mouse_z_delta held at 0
//
// Ports
//   pxl_clk          in   clock, all logic on rising edge
//   pxl_clk_aresetn  in   asynchronous active-low reset
//   rx_data[7:0]     in   received byte
//   rx_valid         in   one-cycle strobe, rx_data valid
//   rx_err           in   one-cycle strobe, receiver parity/framing error
//   mouse_x_pos[11:0]   out  cursor X, 0..X_MAX
//   mouse_y_pos[11:0]   out  cursor Y, 0..Y_MAX (0 = top)
//   mouse_buttons[2:0]  out  {middle, right, left} of last good packet
//   mouse_z_delta[3:0]  out  signed wheel delta of last good packet
//   mouse_err           out  last packet attempt failed
//   new_event           out  one-cycle pulse, outputs just updated
//   fsm_state[2:0]      out  debug view of the packet FSM state
//
// Handshake: a byte is consumed in every cycle where rx_valid is high; there
// is no backpressure. rx_err in the same cycle overrides rx_valid.
// -----------------------------------------------------------------------------
module mouse_pos_tracker #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        pxl_clk,
  input  logic        pxl_clk_aresetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [11:0] mouse_x_pos,
  output logic [11:0] mouse_y_pos,
  output logic [2:0]  mouse_buttons,
  output logic [3:0]  mouse_z_delta,
  output logic        mouse_err,
  output logic        new_event,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYTE1  = 3'd1,
    BYTE2  = 3'd2,
`ifdef MOUSE_WHEEL_EN
    BYTE3  = 3'd3,
`endif
    UPDATE = 3'd4
  } state_t;

`ifdef MOUSE_WHEEL_EN
  localparam state_t LAST_ST = BYTE3;
`else
  localparam state_t LAST_ST = BYTE2;
`endif

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [13:0] X_LIM = 14'(X_MAX);
  localparam logic signed [13:0] Y_LIM = 14'(Y_MAX);

  state_t          state;
  logic [CW-1:0]   to_cnt;
  logic [1:0]      hdr_ovf;   // [1]=Y overflow, [0]=X overflow
  logic [1:0]      hdr_sign;  // [1]=Y sign, [0]=X sign
  logic [2:0]      hdr_btn;
  logic [7:0]      x_byte;
`ifdef MOUSE_WHEEL_EN
  logic [7:0]      y_byte;
`endif

  logic [7:0]         y_src;
  logic signed [8:0]  dx, dy;
  logic signed [13:0] x_sum, y_sum;
  logic [11:0]        x_next, y_next;
  logic               last_byte;

  assign fsm_state = state;

  // The position update is computed from the byte arriving now, so the
  // registered result lands in the cycle right after the final rx_valid.
  always_comb begin
`ifdef MOUSE_WHEEL_EN
    y_src = y_byte;
`else
    y_src = rx_data;
`endif
    dx = hdr_ovf[0] ? 9'sd0 : $signed({hdr_sign[0], x_byte});
    dy = hdr_ovf[1] ? 9'sd0 : $signed({hdr_sign[1], y_src});
    x_sum = $signed({2'b00, mouse_x_pos}) + $signed({{5{dx[8]}}, dx});
    // PS/2 Y grows upward, screen Y grows downward.
    y_sum = $signed({2'b00, mouse_y_pos}) - $signed({{5{dy[8]}}, dy});

    if (x_sum < 14'sd0)      x_next = 12'd0;
    else if (x_sum > X_LIM)  x_next = 12'(X_MAX);
    else                     x_next = x_sum[11:0];

    if (y_sum < 14'sd0)      y_next = 12'd0;
    else if (y_sum > Y_LIM)  y_next = 12'(Y_MAX);
    else                     y_next = y_sum[11:0];

    last_byte = rx_valid && !rx_err && (state == LAST_ST);
  end

  always_ff @(posedge pxl_clk or negedge pxl_clk_aresetn) begin
    if (!pxl_clk_aresetn) begin
      state         <= IDLE;
      to_cnt        <= '0;
      hdr_ovf       <= '0;
      hdr_sign      <= '0;
      hdr_btn       <= '0;
      x_byte        <= '0;
`ifdef MOUSE_WHEEL_EN
      y_byte        <= '0;
`endif
      mouse_x_pos   <= 12'(X_MAX >> 1);
      mouse_y_pos   <= 12'(Y_MAX >> 1);
      mouse_buttons <= '0;
      mouse_z_delta <= '0;
      mouse_err     <= 1'b0;
      new_event     <= 1'b0;
    end else begin
      new_event <= 1'b0;

      if (rx_err) begin
        state     <= IDLE;
        mouse_err <= 1'b1;
        to_cnt    <= '0;
      end else begin
        case (state)
          // UPDATE behaves like IDLE for an incoming byte so a header sent
          // back-to-back with the previous packet's last byte is not lost.
          IDLE, UPDATE: begin
            to_cnt <= '0;
            state  <= IDLE;
            if (rx_valid) begin
              if (rx_data[3]) begin
                hdr_ovf  <= rx_data[7:6];
                hdr_sign <= rx_data[5:4];
                hdr_btn  <= rx_data[2:0];
                state    <= BYTE1;
              end else begin
                mouse_err <= 1'b1;
              end
            end
          end

          default: begin
            if (rx_valid) begin
              to_cnt <= '0;
              case (state)
                BYTE1: begin
                  x_byte <= rx_data;
                  state  <= BYTE2;
                end
`ifdef MOUSE_WHEEL_EN
                BYTE2: begin
                  y_byte <= rx_data;
                  state  <= BYTE3;
                end
`endif
                default: state <= UPDATE;
              endcase
            end else if (to_cnt == TO_LAST) begin
              mouse_err <= 1'b1;
              state     <= IDLE;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        endcase
      end

      if (last_byte) begin
        mouse_x_pos   <= x_next;
        mouse_y_pos   <= y_next;
        mouse_buttons <= hdr_btn;
`ifdef MOUSE_WHEEL_EN
        mouse_z_delta <= rx_data[3:0];
`endif
        mouse_err     <= 1'b0;
        new_event     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
module tb_mouse_pos_tracker;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int T     = 40;
  localparam int W     = 32;

  logic        pxl_clk;
  logic        pxl_clk_aresetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [11:0] mouse_x_pos;
  logic [11:0] mouse_y_pos;
  logic [2:0]  mouse_buttons;
  logic [3:0]  mouse_z_delta;
  logic        mouse_err;
  logic        new_event;
  logic [2:0]  fsm_state;

  mouse_pos_tracker #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYCLES(T)
  ) dut (
    .pxl_clk(pxl_clk),
    .pxl_clk_aresetn(pxl_clk_aresetn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_err(rx_err),
    .mouse_x_pos(mouse_x_pos),
    .mouse_y_pos(mouse_y_pos),
    .mouse_buttons(mouse_buttons),
    .mouse_z_delta(mouse_z_delta),
    .mouse_err(mouse_err),
    .new_event(new_event),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  int events   = 0;
  int exp_events = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int mx, my;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push_expect(input logic [7:0] h, input logic [7:0] xb,
                             input logic [7:0] yb, input logic [7:0] zb);
    int dx, dy;
    logic [3:0] z;
    dx = h[6] ? 0 : (h[4] ? int'(xb) - 256 : int'(xb));
    dy = h[7] ? 0 : (h[5] ? int'(yb) - 256 : int'(yb));
    mx = clampi(mx + dx, X_MAX);
    my = clampi(my - dy, Y_MAX);
`ifdef MOUSE_WHEEL_EN
    z = zb[3:0];
`else
    z = 4'd0;
`endif
    exp_q.push_back({12'(mx), 12'(my), h[2:0], z, 1'b0});
    exp_events++;
  endtask

  always @(negedge pxl_clk) begin
    if (pxl_clk_aresetn && new_event) begin
      events++;
      check("event_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("event_fields",
              {mouse_x_pos, mouse_y_pos, mouse_buttons, mouse_z_delta, mouse_err},
              exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge pxl_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    @(posedge pxl_clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] h, input logic [7:0] xb,
                             input logic [7:0] yb, input logic [7:0] zb,
                             input bit chk_latency);
    push_expect(h, xb, yb, zb);
    send_byte(h, 1'b0);
    send_byte(xb, 1'b0);
    send_byte(yb, 1'b0);
`ifdef MOUSE_WHEEL_EN
    send_byte(zb, 1'b0);
`endif
    if (chk_latency) begin
      @(negedge pxl_clk);
      check("latency", 32'(new_event), 32'd1);
      idle(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
    pxl_clk_aresetn = 1'b0;
    mx = X_MAX >> 1;
    my = Y_MAX >> 1;
    repeat (3) @(posedge pxl_clk);
    @(negedge pxl_clk);
    pxl_clk_aresetn = 1'b1;
    idle(1);

    check("rst_x", 32'(mouse_x_pos), 32'd319);
    check("rst_y", 32'(mouse_y_pos), 32'd239);
    check("rst_btn", 32'(mouse_buttons), 32'd0);
    check("rst_z", 32'(mouse_z_delta), 32'd0);
    check("rst_err", 32'(mouse_err), 32'd0);
    check("rst_evt", 32'(new_event), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);

    // Basic packet.
    send_packet(8'h09, 8'h05, 8'h03, 8'h00, 1);
    check("basic_x", 32'(mouse_x_pos), 32'd324);
    check("basic_y", 32'(mouse_y_pos), 32'd236);
    check("basic_btn", 32'(mouse_buttons), 32'd1);

    // Walk to x=635, then clamp high and reverse.
    send_packet(8'h08, 8'hFF, 8'h00, 8'h00, 1);
    send_packet(8'h08, 8'h38, 8'h00, 8'h00, 1);
    check("x_635", 32'(mouse_x_pos), 32'd635);
    send_packet(8'h08, 8'h0A, 8'h00, 8'h00, 1);
    check("x_clamp_hi", 32'(mouse_x_pos), 32'd639);
    send_packet(8'h18, 8'hF6, 8'h00, 8'h00, 1);
    check("x_reverse", 32'(mouse_x_pos), 32'd629);

    // X overflow ignores the X byte.
    send_packet(8'h48, 8'h50, 8'h00, 8'h00, 1);
    check("x_ovf", 32'(mouse_x_pos), 32'd629);

    // Y clamp at top, then follow reverse motion.
    send_packet(8'h08, 8'h00, 8'h7F, 8'h00, 1);
    send_packet(8'h08, 8'h00, 8'h7F, 8'h00, 1);
    check("y_clamp_lo", 32'(mouse_y_pos), 32'd0);
    send_packet(8'h28, 8'h00, 8'hF6, 8'h00, 1);
    check("y_reverse", 32'(mouse_y_pos), 32'd10);

    // X clamp at zero, then follow.
    for (int i = 0; i < 3; i++) send_packet(8'h18, 8'h01, 8'h00, 8'h00, 1);
    check("x_clamp_lo", 32'(mouse_x_pos), 32'd0);
    send_packet(8'h08, 8'h05, 8'h00, 8'h00, 1);
    check("x_follow", 32'(mouse_x_pos), 32'd5);

`ifdef MOUSE_WHEEL_EN
    send_packet(8'h08, 8'h00, 8'h00, 8'h0F, 1);
    check("wheel_z", 32'(mouse_z_delta), 32'hF);
`endif

    // Timeout: one cycle short keeps the packet, the full count drops it.
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    idle(T - 1);
    check("to_pre_err", 32'(mouse_err), 32'd0);
    check("to_pre_state", 32'(fsm_state), 32'd2);
    idle(1);
    check("to_err", 32'(mouse_err), 32'd1);
    check("to_state", 32'(fsm_state), 32'd0);
    send_packet(8'h08, 8'h00, 8'h00, 8'h00, 1);
    check("to_recover_err", 32'(mouse_err), 32'd0);

    // Maximal legal gaps between bytes.
    push_expect(8'h0A, 8'h02, 8'h01, 8'h03);
    send_byte(8'h0A, 1'b0); idle(T - 1);
    send_byte(8'h02, 1'b0); idle(T - 1);
    send_byte(8'h01, 1'b0);
`ifdef MOUSE_WHEEL_EN
    idle(T - 1);
    send_byte(8'h03, 1'b0);
`endif
    idle(2);

    // rx_err wins over rx_valid; bare non-header byte stays in error.
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    check("rxerr_err", 32'(mouse_err), 32'd1);
    check("rxerr_state", 32'(fsm_state), 32'd0);
    send_byte(8'h00, 1'b0);
    check("bare_err", 32'(mouse_err), 32'd1);
    check("bare_state", 32'(fsm_state), 32'd0);

    // Back-to-back packets: next header arrives during UPDATE.
    send_packet(8'h0C, 8'h10, 8'h04, 8'h02, 0);
    send_packet(8'h0B, 8'h03, 8'hFE, 8'h01, 1);

    // Asynchronous reset mid-packet.
    send_byte(8'h08, 1'b0);
    send_byte(8'h7F, 1'b0);
    #3;
    pxl_clk_aresetn = 1'b0;
    #1;
    check("arst_state", 32'(fsm_state), 32'd0);
    check("arst_x", 32'(mouse_x_pos), 32'd319);
    check("arst_y", 32'(mouse_y_pos), 32'd239);
    mx = X_MAX >> 1;
    my = Y_MAX >> 1;
    @(negedge pxl_clk);
    pxl_clk_aresetn = 1'b1;
    idle(1);
    send_byte(8'h03, 1'b0);
    check("arst_drop_err", 32'(mouse_err), 32'd1);
    idle(2);

    // Random packets.
    for (int i = 0; i < 20; i++) begin
      send_packet(8'($urandom_range(0, 255)) | 8'h08, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("event_count", 32'(events), 32'(exp_events));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 Parameter X_MAX, default 639, largest legal mouse_x_pos value.
REQ-002 Parameter Y_MAX, default 479, largest legal mouse_y_pos value.
REQ-003 Parameter TIMEOUT_CYCLES, default 2_000_000, maximum idle pxl_clk cycles between bytes of one packet.
REQ-004 pxl_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 pxl_clk_aresetn  input  1  reset; asynchronous assert, active-low.
REQ-006 rx_data  input  8  byte from the PS/2 byte receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-008 rx_err  input  1  one-cycle strobe; receiver parity or framing error.
REQ-009 mouse_x_pos  output  12  current X position, 0..X_MAX.
REQ-010 mouse_y_pos  output  12  current Y position, 0..Y_MAX, 0 = top of screen.
REQ-011 mouse_buttons  output  3  {middle, right, left} from the last good packet.
REQ-012 mouse_z_delta  output  4  signed wheel delta from the last good packet.
REQ-013 mouse_err  output  1  last packet attempt failed.
REQ-014 new_event  output  1  one-cycle pulse; positions, buttons and z_delta just updated.

Function
REQ-015 FSM states SHALL be IDLE, BYTE1, BYTE2, BYTE3 and UPDATE; the reset state SHALL be IDLE.
REQ-016 IDLE SHALL wait for rx_valid. If rx_data[3]=1, it SHALL store rx_data as the header and go to BYTE1. If rx_data[3]=0, it SHALL discard the byte, set mouse_err and stay in IDLE.
REQ-017 In BYTE1, rx_valid SHALL store the X delta and move to BYTE2.
REQ-018 In BYTE2, rx_valid SHALL store the Y delta and move to BYTE3 when MOUSE_WHEEL_EN is defined, otherwise to UPDATE.
REQ-019 In BYTE3, rx_valid SHALL store rx_data[3:0] as the Z delta and move to UPDATE.
REQ-020 Deltas SHALL be 9-bit two's complement: {header[4], X byte} for X and {header[5], Y byte} for Y.
REQ-021 If header[6] (X overflow) is set, the X delta SHALL be treated as 0; header[7] SHALL do the same for Y.
REQ-022 UPDATE SHALL last exactly one cycle and return to IDLE.
REQ-023 UPDATE SHALL set x = clamp(x + dx, 0, X_MAX) and y = clamp(y - dy, 0, Y_MAX), using 14-bit signed intermediates.
REQ-024 UPDATE SHALL also set mouse_buttons = header[2:0] and load mouse_z_delta, clear mouse_err and pulse new_event.
REQ-025 Outputs SHALL be registered. new_event SHALL be high in the cycle after the final byte's rx_valid, and the new values SHALL be visible in that same cycle.
REQ-026 rx_err in any state SHALL discard the packet in progress, set mouse_err and return to IDLE. rx_err SHALL win over a simultaneous rx_valid.
REQ-027 A byte counter SHALL reset on every rx_valid. In BYTE1, BYTE2 or BYTE3, TIMEOUT_CYCLES cycles without rx_valid SHALL set mouse_err, discard the partial packet and return to IDLE.
REQ-028 rx_valid arriving while in UPDATE SHALL be handled as an IDLE byte in the same cycle, so no byte is lost.
REQ-029 Positions SHALL never leave their ranges. A saturated axis SHALL stay at its limit and follow later reverse motion immediately.

Reset
REQ-030 Assertion of pxl_clk_aresetn SHALL take effect immediately, without waiting for a clock edge.
REQ-031 Reset state: FSM = IDLE; mouse_x_pos = X_MAX>>1; mouse_y_pos = Y_MAX>>1; mouse_buttons = 0; mouse_z_delta = 0; mouse_err = 0; new_event = 0; timeout counter = 0.
REQ-032 Reset mid-packet SHALL drop all partial data; no new_event SHALL be produced for that packet.

Configuration
REQ-033 Macro MOUSE_WHEEL_EN defined: packets SHALL be 4 bytes, and mouse_z_delta SHALL be loaded from byte 3 bits [3:0] at UPDATE.
REQ-034 Macro MOUSE_WHEEL_EN undefined: packets SHALL be 3 bytes, the BYTE3 state SHALL be absent, and mouse_z_delta SHALL be held at 0.

Verification
REQ-035 After reset, send bytes 0x09, 0x05, 0x03 (3-byte build) -> new_event one cycle after the last rx_valid, x=324, y=236, buttons=3'b001, err=0.
REQ-036 From x=635, send header 0x08, X=0x0A -> x=639 (clamped). Then send header 0x18, X=0xF6 (dx=-10) -> x=629.
REQ-037 Send header 0x48 (X overflow) with X=0x50, Y=0x00 -> x unchanged, new_event pulses.
REQ-038 Send 0x08, 0x05, then no byte for TIMEOUT_CYCLES -> mouse_err=1, no new_event. Then send 0x08, 0x00, 0x00 -> err=0, one new_event.
REQ-039 Assert rx_err together with rx_valid on byte 2 -> err=1, FSM returns to IDLE. Send a bare byte 0x00 -> discarded, err stays 1.
REQ-040 With MOUSE_WHEEL_EN defined, send 0x08, 0x00, 0x00, 0x0F -> mouse_z_delta=4'hF (-1), new_event one cycle after the 4th byte.
